dp_pipe: RTL and testbench

- Parametrised two-stage pipelined datapath. It succeeds the single-cycle DATAPATH block.
- Contains a REGS x SIZE register file (2 read ports, 1 write port), an operand stage, and an execute/writeback stage with an ALU and a barrel shifter.
- Adds operand forwarding, a stall input, and issue/result valid tracking.
- Sits between the control unit (which drives the control word) and data_memory (driven by Addr_out/Data_out).

---
 rtl/dp_pipe.sv | 166 ++++++++++++++++
 tb/tb_dp_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_pipe.sv
// Two-stage pipelined datapath: register file + operand stage, then execute/writeback (ALU, barrel shifter).
// Optional macro DP_FWD_EN adds an EX-to-OP operand bypass for back-to-back dependent ops.
module dp_pipe #(
  parameter int SIZE = 32,
  parameter int REGS = 32,
  localparam int AW = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            stall,
  input  logic            we,
  input  logic            MuxB_sel,
  input  logic            MuxD_sel,
  input  logic            MuxR_sel,
  input  logic [3:0]      Sel,
  input  logic [AW-1:0]   AA,
  input  logic [AW-1:0]   BA,
  input  logic [AW-1:0]   DA,
  input  logic [SIZE-1:0] PC_in,
  input  logic [SIZE-1:0] Data_in,
  input  logic [SIZE-1:0] Constant_in,
  output logic [SIZE-1:0] Addr_out,
  output logic [SIZE-1:0] Data_out,
  output logic [SIZE-1:0] result_out,
  output logic            valid_out,
  output logic            C,
  output logic            V,
  output logic            N,
  output logic            Z
);
  localparam int SW = $clog2(SIZE);

  logic [SIZE-1:0] rf [REGS];

  // EX pipeline register
  logic            ex_valid;
  logic            ex_we;
  logic            ex_muxd;
  logic            ex_muxr;
  logic [2:0]      ex_sel;
  logic [AW-1:0]   ex_da;
  logic [SIZE-1:0] ex_a;
  logic [SIZE-1:0] ex_b;
  logic [SIZE-1:0] ex_breg;
  logic [SIZE-1:0] ex_data;
  logic [SIZE-1:0] ex_pc;

  logic [SIZE-1:0] rd_a;
  logic [SIZE-1:0] rd_b;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;

  logic [SIZE-1:0]   ex_res;
  logic              ex_c;
  logic              ex_v;
  logic [SIZE-1:0]   wb_val;
  logic [SIZE:0]     sum;
  logic [SIZE-1:0]   b_add;
  logic              is_sub;
  logic [2*SIZE-1:0] rot;
  logic [SW-1:0]     sh;

  assign wb_val = ex_muxd ? ex_data : ex_res;

  // Operand read; r0 is hardwired to zero.
  always_comb begin
    rd_a = (AA == '0) ? '0 : rf[AA];
    rd_b = (BA == '0) ? '0 : rf[BA];
`ifdef DP_FWD_EN
    if (ex_valid && ex_we && (ex_da != '0)) begin
      if (ex_da == AA) rd_a = wb_val;
      if (ex_da == BA) rd_b = wb_val;
    end
`endif
    op_a = ((AA == '0) && (Sel == 4'b0111)) ? PC_in : rd_a;
    op_b = MuxB_sel ? Constant_in : rd_b;
  end

  always_comb begin
    is_sub = (ex_sel == 3'b001);
    b_add  = is_sub ? ~ex_b : ex_b;
    sum    = {1'b0, ex_a} + {1'b0, b_add} + {{SIZE{1'b0}}, is_sub};
    sh     = ex_b[SW-1:0];
    rot    = {ex_a, ex_a} << sh;
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    if (ex_muxr) begin
      case (ex_sel[1:0])
        2'b00:   ex_res = ex_a << sh;
        2'b01:   ex_res = ex_a >> sh;
        2'b10:   ex_res = $signed(ex_a) >>> sh;
        default: ex_res = rot[2*SIZE-1:SIZE];
      endcase
    end else begin
      case (ex_sel)
        3'b000, 3'b001: begin
          ex_res = sum[SIZE-1:0];
          ex_c   = sum[SIZE];
          ex_v   = (ex_a[SIZE-1] == b_add[SIZE-1]) && (sum[SIZE-1] != ex_a[SIZE-1]);
        end
        3'b010:  ex_res = ex_a & ex_b;
        3'b011:  ex_res = ex_a | ex_b;
        3'b100:  ex_res = ex_a ^ ex_b;
        3'b101:  ex_res = {{(SIZE-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
        3'b110:  ex_res = ex_b;
        default: ex_res = ex_pc;
      endcase
    end
  end

  // Handshake: an op is accepted at an edge where valid_in=1 and stall=0; stall=1
  // freezes both stages, so the control unit must hold the op until stall drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
      ex_valid   <= 1'b0;
      ex_we      <= 1'b0;
      ex_muxd    <= 1'b0;
      ex_muxr    <= 1'b0;
      ex_sel     <= '0;
      ex_da      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_breg    <= '0;
      ex_data    <= '0;
      ex_pc      <= '0;
      result_out <= '0;
      valid_out  <= 1'b0;
      C          <= 1'b0;
      V          <= 1'b0;
      N          <= 1'b0;
      Z          <= 1'b0;
    end else if (stall) begin
      valid_out <= 1'b0;
    end else begin
      if (ex_valid) begin
        if (ex_we && (ex_da != '0)) rf[ex_da] <= wb_val;
        result_out <= wb_val;
        C <= ex_c;
        V <= ex_v;
        N <= ex_res[SIZE-1];
        Z <= (ex_res == '0);
      end
      valid_out <= ex_valid;
      ex_valid  <= valid_in;
      // Payload only moves on a real op so Addr_out/Data_out hold across bubbles.
      if (valid_in) begin
        ex_we   <= we;
        ex_muxd <= MuxD_sel;
        ex_muxr <= MuxR_sel;
        ex_sel  <= Sel[2:0];
        ex_da   <= DA;
        ex_a    <= op_a;
        ex_b    <= op_b;
        ex_breg <= rd_b;
        ex_data <= Data_in;
        ex_pc   <= PC_in;
      end
    end
  end

  assign Addr_out = ex_a;
  assign Data_out = ex_breg;
endmodule

// File: tb/tb_dp_pipe.sv
// Self-checking bench for dp_pipe (SIZE=32, REGS=32): directed plan plus random ops
// against an arithmetic reference model; expected writeback values flow through exp_q.
module tb_dp_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, stall, we, MuxB_sel, MuxD_sel, MuxR_sel;
  logic [3:0]  Sel;
  logic [4:0]  AA, BA, DA;
  logic [31:0] PC_in, Data_in, Constant_in;
  logic [31:0] Addr_out, Data_out, result_out;
  logic        valid_out, C, V, N, Z;

  int n_cmp = 0;
  int n_err = 0;

  dp_pipe #(.SIZE(32), .REGS(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .we(we),
    .MuxB_sel(MuxB_sel), .MuxD_sel(MuxD_sel), .MuxR_sel(MuxR_sel), .Sel(Sel),
    .AA(AA), .BA(BA), .DA(DA), .PC_in(PC_in), .Data_in(Data_in),
    .Constant_in(Constant_in), .Addr_out(Addr_out), .Data_out(Data_out),
    .result_out(result_out), .valid_out(valid_out), .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  da;
    logic [31:0] res;
    logic        c;
    logic        v;
  } op_t;

  logic [31:0] m_rf [32];
  logic [31:0] exp_q [$];
  op_t         pend;
  logic [31:0] e_res, e_addr, e_data;
  logic        e_valid, e_c, e_v, e_n, e_z;

  function automatic logic in_range(input longint x);
    return (x <= 64'sd2147483647) && (x >= -64'sd2147483648);
  endfunction

  // Operation semantics from the op table, computed with wide arithmetic and bit loops.
  function automatic void exec(input logic [3:0] sel, input logic muxr,
                               input logic [31:0] a, b, pc,
                               output logic [31:0] r, output logic c, output logic v);
    longint      sa, sb;
    logic [63:0] t;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r = '0; c = 1'b0; v = 1'b0;
    if (muxr) begin
      for (int i = 0; i < 32; i++) begin
        case (sel[1:0])
          2'b00: r[i] = (i >= sh) ? a[i-sh] : 1'b0;
          2'b01: r[i] = (i + sh < 32) ? a[i+sh] : 1'b0;
          2'b10: r[i] = (i + sh < 32) ? a[i+sh] : a[31];
          default: r[(i+sh)%32] = a[i];
        endcase
      end
    end else begin
      case (sel[2:0])
        3'd0: begin
          t = {32'd0, a} + {32'd0, b};
          r = t[31:0]; c = t[32]; v = !in_range(sa + sb);
        end
        3'd1: begin
          r = a - b; c = (a >= b); v = !in_range(sa - sb);
        end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd6: r = b;
        default: r = pc;
      endcase
    end
  endfunction

  task automatic model_edge();
    op_t         nxt;
    logic [31:0] ra, rb, a, b, wbv, r;
    logic        c, v;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      exp_q.delete();
      pend = '{default: '0};
      {e_res, e_addr, e_data} = '0;
      {e_valid, e_c, e_v, e_n, e_z} = '0;
      return;
    end
    if (stall) begin
      e_valid = 1'b0;
      return;
    end
    wbv = pend.valid ? exp_q[0] : '0;
    nxt = '{default: '0};
    if (valid_in) begin
      ra = m_rf[AA];
      rb = m_rf[BA];
`ifdef DP_FWD_EN
      if (pend.valid && pend.we && pend.da != 0) begin
        if (pend.da == AA) ra = wbv;
        if (pend.da == BA) rb = wbv;
      end
`endif
      a = (AA == 0 && Sel == 4'b0111) ? PC_in : ra;
      b = MuxB_sel ? Constant_in : rb;
      exec(Sel, MuxR_sel, a, b, PC_in, r, c, v);
      nxt.valid = 1'b1; nxt.we = we; nxt.da = DA;
      nxt.res = r; nxt.c = c; nxt.v = v;
      e_addr = a;
      e_data = rb;
    end
    if (pend.valid) begin
      wbv = exp_q.pop_front();
      if (pend.we && pend.da != 0) m_rf[pend.da] = wbv;
      e_res = wbv;
      e_c = pend.c; e_v = pend.v;
      e_n = pend.res[31]; e_z = (pend.res == 0);
    end
    e_valid = pend.valid;
    if (nxt.valid) exp_q.push_back(MuxD_sel ? Data_in : nxt.res);
    pend = nxt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    check("result_out", result_out, e_res);
    check("flag_C", {31'd0, C}, {31'd0, e_c});
    check("flag_V", {31'd0, V}, {31'd0, e_v});
    check("flag_N", {31'd0, N}, {31'd0, e_n});
    check("flag_Z", {31'd0, Z}, {31'd0, e_z});
    check("Addr_out", Addr_out, e_addr);
    check("Data_out", Data_out, e_data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic issue(input logic [3:0] sel, input logic muxr, muxb, muxd, w,
                       input logic [4:0] aa, ba, da, input logic [31:0] k, d, pc);
    valid_in = 1'b1; stall = 1'b0;
    Sel = sel; MuxR_sel = muxr; MuxB_sel = muxb; MuxD_sel = muxd; we = w;
    AA = aa; BA = ba; DA = da; Constant_in = k; Data_in = d; PC_in = pc;
    step();
  endtask

  task automatic bubble();
    valid_in = 1'b0; stall = 1'b0;
    step();
  endtask

  // Show RF[r] on result_out two edges later without writing anything.
  task automatic read_reg(input logic [4:0] r);
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bubble();
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; stall = 1'b0; we = 1'b0;
    MuxB_sel = 1'b0; MuxD_sel = 1'b0; MuxR_sel = 1'b0; Sel = '0;
    AA = '0; BA = '0; DA = '0; PC_in = '0; Data_in = '0; Constant_in = '0;
    repeat (2) step();
    check("reset_result", result_out, 32'd0);
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    reset = 1'b1;

    // ADD r1 = r0 + 1
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd1, 32'd0, 32'd0);
    bubble();
    check("addi_result", result_out, 32'd1);
    check("addi_valid", {31'd0, valid_out}, 32'd1);
    check("addi_Z", {31'd0, Z}, 32'd0);

    // ADDI r6 = r0 + 1 then SLL r2 = r6 << 1 back to back
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 32'd1, 32'd0, 32'd0);
    issue(4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd0, 5'd2, 32'd1, 32'd0, 32'd0);
    bubble();
`ifdef DP_FWD_EN
    check("fwd_sll", result_out, 32'd2);
`else
    check("nofwd_sll", result_out, 32'd0);
`endif

    // Signed overflow: r3 = 0x7FFFFFFF, r4 = r3 + 1
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h7FFF_FFFF, 32'd0, 32'd0);
    bubble();
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd4, 32'd1, 32'd0, 32'd0);
    bubble();
    check("ovf_result", result_out, 32'h8000_0000);
    check("ovf_flags_CVNZ", {28'd0, C, V, N, Z}, 32'b0110);

    // SUB r5 = r1 - r1
    issue(4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd1, 5'd5, 32'd0, 32'd0, 32'd0);
    bubble();
    check("sub_result", result_out, 32'd0);
    check("sub_flags_CVNZ", {28'd0, C, V, N, Z}, 32'b1001);

    // Write to r0 still drives result_out; r0 keeps reading 0
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0);
    bubble();
    check("r0_write_result", result_out, 32'd5);
    read_reg(5'd0);
    check("r0_reads_zero", result_out, 32'd0);

    // Stall for 3 cycles with r7 = 0x55 sitting in EX
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h55, 32'd0, 32'd0);
    stall = 1'b1; valid_in = 1'b1; DA = 5'd9; Constant_in = 32'hDEAD;
    repeat (3) begin
      step();
      check("stall_valid", {31'd0, valid_out}, 32'd0);
    end
    bubble();
    check("stall_release_valid", {31'd0, valid_out}, 32'd1);
    check("stall_release_result", result_out, 32'h55);
    bubble();
    check("stall_single_wb", {31'd0, valid_out}, 32'd0);
    read_reg(5'd7);
    check("stall_r7", result_out, 32'h55);
    read_reg(5'd9);
    check("stall_r9_untouched", result_out, 32'd0);

    // Reset while r8 write sits in EX
    issue(4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 32'h99, 32'd0, 32'd0);
    reset = 1'b0; valid_in = 1'b0;
    step();
    check("rst_outputs", {result_out | Addr_out | Data_out}, 32'd0);
    check("rst_flags_valid", {27'd0, valid_out, C, V, N, Z}, 32'd0);
    reset = 1'b1;
    read_reg(5'd8);
    check("rst_r8_dropped", result_out, 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      valid_in    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 7) == 0);
      we          = $urandom_range(0, 1);
      MuxB_sel    = $urandom_range(0, 1);
      MuxD_sel    = ($urandom_range(0, 3) == 0);
      MuxR_sel    = ($urandom_range(0, 2) == 0);
      Sel         = 4'($urandom_range(0, 15));
      AA          = 5'($urandom_range(0, 7));
      BA          = 5'($urandom_range(0, 7));
      DA          = 5'($urandom_range(0, 7));
      Constant_in = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      Data_in     = $urandom;
      PC_in       = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
